// File: rtl/hough_pkg.sv
// hough_pkg: shared Hough accumulator defaults and reader state encoding.
package hough_pkg;
  localparam int D_THETAS = 180;
  localparam int D_RHOS = 1600;
  localparam int D_VOTE_WIDTH = 16;
  localparam int D_MAX_LINES = 16;
  localparam int D_ADDR_WIDTH = $clog2(D_THETAS * D_RHOS);
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, EMIT, DONE} state_t;
endpackage

// File: rtl/accum_peak_reader.sv
// accum_peak_reader: scans the accumulator, streams cells at/above threshold and clears every visited cell.
module accum_peak_reader
  import hough_pkg::*;
#(
  parameter int THETAS = D_THETAS,
  parameter int RHOS = D_RHOS,
  parameter int VOTE_WIDTH = D_VOTE_WIDTH,
  parameter int MAX_LINES = D_MAX_LINES,
  parameter int ADDR_WIDTH = $clog2(THETAS * RHOS),
  localparam int TW = $clog2(THETAS),
  localparam int RW = $clog2(RHOS),
  localparam int LW = $clog2(MAX_LINES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VOTE_WIDTH-1:0] threshold,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_rd_en,
  output logic [ADDR_WIDTH-1:0] acc_rd_addr,
  input  logic [VOTE_WIDTH-1:0] acc_rd_data,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic [VOTE_WIDTH-1:0] acc_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TW-1:0]         out_theta,
  output logic [RW-1:0]         out_rho,
  output logic [VOTE_WIDTH-1:0] out_votes,
  output logic [LW-1:0]         line_count
);
  state_t state;
  logic [VOTE_WIDTH-1:0] thr;
  logic [TW-1:0] theta;
  logic [RW-1:0] rho, next_rho;
  logic [ADDR_WIDTH-1:0] base, next_base;
  logic hit, rho_wrap, last, adv;
  assign acc_wr_data = '0;
  always_comb begin
    hit = acc_rd_data >= thr && line_count < LW'(MAX_LINES);
    rho_wrap = rho == RW'(RHOS - 1);
    last = rho_wrap && theta == TW'(THETAS - 1);
    adv = (state == CHECK && !hit) || (state == EMIT && out_ready);
    next_rho = rho_wrap ? '0 : rho + 1'b1;
    // running row base replaces theta*RHOS
    next_base = rho_wrap ? base + ADDR_WIDTH'(RHOS) : base;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      thr <= '0;
      theta <= '0;
      rho <= '0;
      base <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc_rd_en <= 1'b0;
      acc_rd_addr <= '0;
      acc_wr_en <= 1'b0;
      acc_wr_addr <= '0;
      out_valid <= 1'b0;
      out_theta <= '0;
      out_rho <= '0;
      out_votes <= '0;
      line_count <= '0;
    end else begin
      acc_rd_en <= 1'b0;
      acc_wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            thr <= threshold;
            line_count <= '0;
            theta <= '0;
            rho <= '0;
            base <= '0;
            acc_rd_en <= 1'b1;
            acc_rd_addr <= '0;
            state <= WAIT;
          end
        end
        WAIT: state <= CHECK;
        CHECK: begin
          acc_wr_en <= 1'b1;
          acc_wr_addr <= acc_rd_addr;
          if (hit) begin
            out_theta <= theta;
            out_rho <= rho;
            out_votes <= acc_rd_data;
            out_valid <= 1'b1;
            line_count <= line_count + 1'b1;
            state <= EMIT;
          end
        end
        EMIT: out_valid <= out_valid && !out_ready;
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (last) state <= DONE;
        else begin
          rho <= next_rho;
          theta <= rho_wrap ? theta + 1'b1 : theta;
          base <= next_base;
          acc_rd_en <= 1'b1;
          acc_rd_addr <= next_base + ADDR_WIDTH'(next_rho);
          state <= WAIT;
        end
      end
    end
  end
endmodule

// File: tb/tb_accum_peak_reader.sv
// tb_accum_peak_reader: randomized and directed scans of a 4x8 accumulator against a queue-based reference.
module tb_accum_peak_reader;
  localparam int NC = 32;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] threshold = '0;
  logic busy, done, acc_rd_en, acc_wr_en, out_valid;
  logic [4:0] acc_rd_addr, acc_wr_addr;
  logic [15:0] acc_rd_data, acc_wr_data, out_votes;
  logic out_ready = 1'b1;
  logic [1:0] out_theta, line_count;
  logic [2:0] out_rho;
  logic [15:0] mem [NC];
  int wr_cnt [NC];
  logic [63:0] got [$];
  logic [63:0] exp_q [$];
  logic [63:0] prev_rec;
  logic prev_stall = 1'b0, resume_pend = 1'b0;
  int n_chk = 0, n_pass = 0;
  int stalls = 0, rd_stall = 0, collide = 0, wr_nz = 0, resume_addr = -1;
  int ready_mode = 0, hold = 0;

  accum_peak_reader #(.THETAS(4), .RHOS(8), .VOTE_WIDTH(16), .MAX_LINES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .threshold(threshold),
    .busy(busy), .done(done), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_data(acc_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_theta(out_theta), .out_rho(out_rho), .out_votes(out_votes), .line_count(line_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr];
    if (acc_wr_en) begin
      mem[acc_wr_addr] = acc_wr_data;
      wr_cnt[acc_wr_addr] = wr_cnt[acc_wr_addr] + 1;
    end
  end

  always @(posedge clock) begin
    #1;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2 && out_valid && hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else out_ready = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, req);
  endtask

  always @(negedge clock) begin
    if (prev_stall) chk("stable", {out_valid, out_theta, out_rho, out_votes}, prev_rec);
    if (resume_pend && acc_rd_en) begin
      resume_addr = int'(acc_rd_addr);
      resume_pend = 1'b0;
    end
    if (out_valid && out_ready) begin
      got.push_back({43'b0, out_theta, out_rho, out_votes});
      resume_pend = 1'b1;
    end
    if (out_valid && !out_ready) stalls++;
    if (out_valid && !out_ready && acc_rd_en) rd_stall++;
    if (acc_rd_en && acc_wr_en && acc_rd_addr == acc_wr_addr) collide++;
    if (acc_wr_en && acc_wr_data != 0) wr_nz++;
    prev_stall = out_valid && !out_ready;
    prev_rec = {40'b0, out_valid, out_theta, out_rho, out_votes};
  end

  task automatic clear_mem();
    for (int a = 0; a < NC; a++) mem[a] = '0;
  endtask

  task automatic pulse_start(input logic [15:0] thr);
    @(negedge clock);
    start = 1'b1;
    threshold = thr;
    @(negedge clock);
    start = 1'b0;
    threshold = $urandom_range(0, 65535);
  endtask

  task automatic run_scan(input string name, input logic [15:0] thr, input int mode);
    int n = 0, nz = 0, badw = 0;
    exp_q.delete();
    for (int a = 0; a < NC; a++)
      if (mem[a] >= thr && exp_q.size() < 2) exp_q.push_back({43'b0, 2'(a / 8), 3'(a % 8), mem[a]});
    got.delete();
    for (int a = 0; a < NC; a++) wr_cnt[a] = 0;
    stalls = 0; rd_stall = 0; collide = 0; wr_nz = 0; resume_addr = -1; resume_pend = 1'b0;
    ready_mode = mode;
    hold = 10;
    pulse_start(thr);
    chk({name, ".busy"}, busy, 1);
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({name, ".latency"}, n, 65 + exp_q.size() + stalls);
    chk({name, ".line_count"}, line_count, exp_q.size());
    chk({name, ".nrec"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({name, ".rec"}, got[i], exp_q[i]);
    @(negedge clock);
    chk({name, ".done_once"}, done, 0);
    chk({name, ".busy_low"}, busy, 0);
    for (int a = 0; a < NC; a++) begin
      if (mem[a] != 0) nz++;
      if (wr_cnt[a] != 1) badw++;
    end
    chk({name, ".cleared"}, nz, 0);
    chk({name, ".one_write_each"}, badw, 0);
    chk({name, ".rules"}, {rd_stall[15:0], collide[15:0], wr_nz[15:0]}, 0);
    ready_mode = 0;
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clock);
    chk("reset_state", {busy, done, acc_rd_en, acc_wr_en, out_valid, line_count, out_votes, acc_rd_addr}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    run_scan("all_zero", 16'd5, 0);
    mem[19] = 16'd7;
    run_scan("one_hit", 16'd5, 0);
    chk("one_hit.cell19", mem[19], 0);
    mem[19] = 16'd7;
    run_scan("stall", 16'd5, 2);
    chk("stall.count", stalls, 10);
    chk("stall.resume", resume_addr, 20);
    mem[1] = 16'd10; mem[9] = 16'd10; mem[17] = 16'd10; mem[25] = 16'd10;
    run_scan("cap", 16'd10, 0);
    mem[5] = 16'd6; mem[6] = 16'd5;
    run_scan("boundary", 16'd6, 0);
    run_scan("thr_zero", 16'd0, 1);
    for (int k = 0; k < 5; k++) begin
      for (int a = 0; a < NC; a++) mem[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 20)) : 16'd0;
      run_scan("random", 16'($urandom_range(0, 15)), 1);
    end
    mem[2] = 16'd9; mem[30] = 16'd3;
    pulse_start(16'd1);
    repeat (19) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("midscan_reset", {busy, done, acc_rd_en, acc_wr_en, out_valid, line_count, out_votes, acc_rd_addr, acc_wr_addr}, 0);
    chk("unvisited_kept", mem[30], 16'd3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_scan("after_reset", 16'd1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/accum_peak_reader.md
Name: accum_peak_reader

Overview:
- Reader side of the Hough accumulator buffer. The vote-calculation block writes votes per (theta, rho) cell; this block scans the full buffer after a frame.
- It emits every cell whose vote count is at or above a threshold as a (theta index, rho index, votes) record, over a valid/ready stream.
- It writes zero back to each cell as it visits it, so the buffer is clean for the next frame.
- It sits between the accumulator BRAM and the line-drawing/output stage.

Parameters:
- THETAS, 180, number of theta bins (accumulator columns).
- RHOS, 1600, number of rho bins (accumulator rows). The rho index is already offset by RHOS/2 by the writer.
- VOTE_WIDTH, 16, width of one accumulator cell (unsigned).
- MAX_LINES, 16, maximum records emitted per scan.
- ADDR_WIDTH, $clog2(THETAS*RHOS), accumulator address width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- threshold  in  VOTE_WIDTH  minimum votes for a hit; latched when start is accepted.
- busy  out  1  high from start accepted until done.
- done  out  1  one-cycle pulse at end of scan.
- acc_rd_en  out  1  accumulator read enable.
- acc_rd_addr  out  ADDR_WIDTH  read address = theta*RHOS + rho.
- acc_rd_data  in  VOTE_WIDTH  read data, valid exactly 1 cycle after acc_rd_en (synchronous BRAM).
- acc_wr_en  out  1  clear-write enable.
- acc_wr_addr  out  ADDR_WIDTH  clear-write address.
- acc_wr_data  out  VOTE_WIDTH  always 0.
- out_valid  out  1  record valid.
- out_ready  in  1  downstream accept.
- out_theta  out  $clog2(THETAS)  theta index of the record.
- out_rho  out  $clog2(RHOS)  rho index of the record.
- out_votes  out  VOTE_WIDTH  vote count of the record.
- line_count  out  $clog2(MAX_LINES+1)  records emitted in the current or last scan.

Behaviour:
- Reset (async assert, sync release) clears every output and counter to 0 and sets state IDLE. Reset mid-scan abandons the scan; cells not yet visited are left uncleared.
- States:
  - IDLE: on start, latch threshold, clear line_count, set theta=rho=0, assert acc_rd_en with addr 0, then go to WAIT. busy=1 from the next cycle. start is ignored in all states except IDLE.
  - WAIT: go to CHECK (data returns this edge).
  - CHECK:
    - Always assert acc_wr_en, with acc_wr_addr = current address and data 0.
    - Hit: acc_rd_data >= threshold (unsigned) AND line_count < MAX_LINES. On a hit, register out_theta/out_rho/out_votes, set out_valid=1, increment line_count, go to EMIT.
    - Otherwise, ADVANCE.
  - EMIT: hold out_valid and the record stable while out_ready=0. When out_valid && out_ready, drop out_valid and ADVANCE. There are no reads while stalled.
  - ADVANCE (action, not a state):
    - If the current cell is the last (theta=THETAS-1, rho=RHOS-1), go to DONE.
    - Else increment rho; when rho wraps from RHOS-1 to 0, increment theta. Issue acc_rd_en at the new address and go to WAIT.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Throughput: 2 cycles per non-hit cell. A hit adds 1 cycle plus any stall.
- Scan order is theta-major, rho-minor. Records appear in ascending address order.
- After MAX_LINES records, the remaining cells are still read and cleared but not emitted.
- A read and a clear-write of the same address never occur in the same cycle. The write happens in CHECK, and the next read is to a different address.
- threshold=0 makes every cell a hit, capped at MAX_LINES.
- The address is computed from the counters (theta*RHOS + rho). No multiplier: a running base adds RHOS on theta increment.

Decomposition:
- The hough_pkg package holds THETAS, RHOS, VOTE_WIDTH, ADDR_WIDTH, and the state enum {IDLE, WAIT, CHECK, EMIT, DONE}.
- Single module, no sub-module. The scan counter and FSM are small enough to live inline.

Test Plan (bench with THETAS=4, RHOS=8, MAX_LINES=2, 1-cycle BRAM model):
1. All cells 0, threshold=5, start -> no out_valid; done pulses once, 65 cycles after start is sampled; all 32 cells written 0; busy low after done.
2. Cell addr 19 (theta=2, rho=3) = 7, threshold=5 -> exactly one record: out_theta=2, out_rho=3, out_votes=7; line_count=1; cell 19 reads 0 afterwards.
3. Same as 2 with out_ready held low 10 cycles -> out_valid and the record stay stable 10 cycles; no acc_rd_en during the stall; scan resumes at addr 20 after the handshake.
4. Cells 1, 9, 17, 25 = 10, threshold=10 -> records for addr 1 (theta 0, rho 1) and addr 9 (theta 1, rho 1) only; line_count=2; all four cells cleared.
5. Cell 5 = 6, cell 6 = 5, threshold=6 -> only cell 5 emitted (boundary: equal passes, one below fails).
6. Assert reset at cycle 20 of a scan -> all outputs 0 immediately, state IDLE. A new start then performs a full 32-cell scan with correct done timing.
